debounce_delay_multi: RTL

//  Multi-channel input qualifier and delay filter with runtime-programmable delay and mode.

---
 rtl/debounce_delay_multi_if.sv | 25 ++
 rtl/debounce_delay_multi.sv | 130 +++++++++++++
 2 files changed

// File: rtl/debounce_delay_multi_if.sv
// Channel-bundle interface for the multi-channel debounce/delay qualifier.
// The master drives the raw inputs and configuration; the slave returns the qualified outputs.
interface debounce_delay_multi_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);
  logic [CHANNELS-1:0] din;
  logic [CHANNELS-1:0] ch_clear;
  logic [CNT_W-1:0]    delay_cfg;
  logic                latch_mode;
  logic [CHANNELS-1:0] dout;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic                busy;

  modport master (
    output din, ch_clear, delay_cfg, latch_mode,
    input  dout, rise, fall, busy
  );

  modport slave (
    input  din, ch_clear, delay_cfg, latch_mode,
    output dout, rise, fall, busy
  );
endinterface

// File: rtl/debounce_delay_multi.sv
// N-channel input qualifier: dout follows din only after D consecutive differing cycles,
// with an optional latch mode that holds a raised output until cleared.
module debounce_delay_multi #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  clear,
  debounce_delay_multi_if.slave bus
);

  typedef enum logic [1:0] {WAIT, COUNT, LOCK} state_e;

  state_e              state_r   [CHANNELS];
  state_e              state_nxt [CHANNELS];
  logic [CNT_W-1:0]    cnt_r     [CHANNELS];
  logic [CNT_W-1:0]    cnt_nxt   [CHANNELS];
  logic [CHANNELS-1:0] dout_r, dout_nxt;
  logic [CHANNELS-1:0] rise_r, rise_nxt;
  logic [CHANNELS-1:0] fall_r, fall_nxt;
  logic                busy_r, busy_nxt;
  logic [CNT_W-1:0]    d_eff;
  logic [CNT_W:0]      cnt_inc;
  logic                flip;

  // A programmed delay of zero qualifies on the first differing edge, same as one.
  function automatic logic [CNT_W-1:0] eff_delay(input logic [CNT_W-1:0] cfg);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (cfg == '0) ? one : cfg;
  endfunction

  assign d_eff = eff_delay(bus.delay_cfg);

  always_comb begin
    busy_nxt = 1'b0;
    dout_nxt = dout_r;
    rise_nxt = '0;
    fall_nxt = '0;
    cnt_inc  = '0;
    flip     = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_nxt[i] = state_r[i];
      cnt_nxt[i]   = cnt_r[i];
      flip         = 1'b0;
      // Widened increment so the >= compare can never see a wrapped count.
      cnt_inc      = {1'b0, cnt_r[i]} + {{CNT_W{1'b0}}, 1'b1};

      unique case (state_r[i])
        WAIT: begin
          cnt_nxt[i] = '0;
          if (bus.din[i] != dout_r[i]) begin
            if (d_eff == {{(CNT_W-1){1'b0}}, 1'b1}) begin
              flip = 1'b1;
            end else begin
              cnt_nxt[i]   = {{(CNT_W-1){1'b0}}, 1'b1};
              state_nxt[i] = COUNT;
            end
          end
        end
        COUNT: begin
          if (bus.din[i] == dout_r[i]) begin
            state_nxt[i] = WAIT;
            cnt_nxt[i]   = '0;
          end else if (cnt_inc >= {1'b0, d_eff}) begin
            flip = 1'b1;
          end else begin
            cnt_nxt[i] = cnt_inc[CNT_W-1:0];
          end
        end
        LOCK: begin
          cnt_nxt[i] = '0;
          if (!bus.latch_mode) state_nxt[i] = WAIT;
        end
        default: begin
          state_nxt[i] = WAIT;
          cnt_nxt[i]   = '0;
        end
      endcase

      if (flip) begin
        dout_nxt[i]  = ~dout_r[i];
        cnt_nxt[i]   = '0;
        state_nxt[i] = (!dout_r[i] && bus.latch_mode) ? LOCK : WAIT;
      end

      rise_nxt[i] = dout_nxt[i] & ~dout_r[i];
      fall_nxt[i] = ~dout_nxt[i] & dout_r[i];

      // A channel clear wins over any flip and must not emit a fall pulse.
      if (bus.ch_clear[i]) begin
        state_nxt[i] = WAIT;
        cnt_nxt[i]   = '0;
        dout_nxt[i]  = 1'b0;
        rise_nxt[i]  = 1'b0;
        fall_nxt[i]  = 1'b0;
      end

      busy_nxt = busy_nxt | (state_nxt[i] == COUNT);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_r[i] <= WAIT;
        cnt_r[i]   <= '0;
      end
      dout_r <= '0;
      rise_r <= '0;
      fall_r <= '0;
      busy_r <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_r[i] <= state_nxt[i];
        cnt_r[i]   <= cnt_nxt[i];
      end
      dout_r <= dout_nxt;
      rise_r <= rise_nxt;
      fall_r <= fall_nxt;
      busy_r <= busy_nxt;
    end
  end

  assign bus.dout = dout_r;
  assign bus.rise = rise_r;
  assign bus.fall = fall_r;
  assign bus.busy = busy_r;

endmodule
